bus_fabric: RTL

BUS_FABRIC -- requirements
Module: bus_fabric

---
 rtl/bus_pkg.sv | 27 ++
 rtl/bus_phase_tracker.sv | 80 ++++++++
 rtl/bus_fabric.sv | 97 +++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus fabric: bus-cycle phase names, lock-tracker
// state encodings and the multi-driver detection helper.
package bus_pkg;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  // Two or more bits set: clearing the lowest set bit still leaves something.
  function automatic logic multi_hot(input logic [15:0] v);
    return |(v & (v - 16'd1));
  endfunction

endpackage

// File: rtl/bus_phase_tracker.sv
// Tracks the eight-phase CPU bus cycle, locking onto the sync strobe that
// marks phase A1 and flagging strobes that arrive out of place.
module bus_phase_tracker
  import bus_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       halt,
  input  logic       sync,
  output logic [2:0] phase,
  output logic       locked,
  output logic       sync_err
);

  lock_state_e state_r;
  phase_e      phase_r;
  logic        locked_r;
  logic        sync_err_r;

  // Lock FSM with registered phase, lock flag and sync-error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_UNLOCKED;
      phase_r    <= PH_A1;
      locked_r   <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      sync_err_r <= 1'b0;
      if (!halt) begin
        case (state_r)
          ST_UNLOCKED: begin
            if (sync) begin
              phase_r <= PH_A2;
              state_r <= ST_LOCKING;
            end else begin
              phase_r <= PH_A1;
            end
          end
          ST_LOCKING: begin
            if (sync) begin
              phase_r <= PH_A2;
              if (phase_r == PH_A1) begin
                state_r  <= ST_LOCKED;
                locked_r <= 1'b1;
              end
            end else begin
              phase_r <= phase_e'(phase_r + 3'd1);
            end
          end
          ST_LOCKED: begin
            if (sync) begin
              phase_r <= PH_A2;
              if (phase_r != PH_A1) begin
                sync_err_r <= 1'b1;
                state_r    <= ST_LOCKING;
                locked_r   <= 1'b0;
              end
            end else if (phase_r == PH_A1) begin
              // Expected strobe missing: drop lock, phase parks at A1.
              state_r  <= ST_UNLOCKED;
              locked_r <= 1'b0;
            end else begin
              phase_r <= phase_e'(phase_r + 3'd1);
            end
          end
          default: begin
            state_r  <= ST_UNLOCKED;
            phase_r  <= PH_A1;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign phase    = phase_r;
  assign locked   = locked_r;
  assign sync_err = sync_err_r;

endmodule

// File: rtl/bus_fabric.sv
// Shared-bus fabric: lowest-index-wins resolution of agent drives, contention
// monitoring with sticky error/mask/count, and the bus-cycle phase tracker.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int NUM_AGENTS = 8,
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        halt,
  input  logic                        sync,
  input  logic [NUM_AGENTS*WIDTH-1:0] agent_data_o,
  input  logic [NUM_AGENTS-1:0]       agent_data_en,
  input  logic                        err_clear,
  output logic [WIDTH-1:0]            bus_data,
  output logic                        bus_valid,
  output logic [3:0]                  bus_owner,
  output logic [2:0]                  phase,
  output logic                        locked,
  output logic                        sync_err,
  output logic                        contention,
  output logic                        err_sticky,
  output logic [NUM_AGENTS-1:0]       conflict_mask,
  output logic [CNT_W-1:0]            conflict_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0]      bus_data_s;
  logic                  bus_valid_s;
  logic [3:0]            bus_owner_s;
  logic                  contention_s;
  logic                  contention_r;
  logic                  err_sticky_r;
  logic [NUM_AGENTS-1:0] conflict_mask_r;
  logic [CNT_W-1:0]      conflict_count_r;

  // Priority mux: scanning downward lets the lowest enabled index win last.
  always_comb begin
    bus_data_s  = {WIDTH{1'b0}};
    bus_valid_s = 1'b0;
    bus_owner_s = 4'd0;
    for (int i = NUM_AGENTS - 1; i >= 0; i--) begin
      bus_data_s  = agent_data_en[i] ? agent_data_o[i*WIDTH +: WIDTH] : bus_data_s;
      bus_owner_s = agent_data_en[i] ? 4'(i) : bus_owner_s;
      bus_valid_s = agent_data_en[i] | bus_valid_s;
    end
  end

  assign contention_s = multi_hot(16'(agent_data_en));

  // Contention record; a new contention takes precedence over err_clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contention_r     <= 1'b0;
      err_sticky_r     <= 1'b0;
      conflict_mask_r  <= {NUM_AGENTS{1'b0}};
      conflict_count_r <= {CNT_W{1'b0}};
    end else begin
      contention_r <= contention_s;
      if (contention_s) begin
        err_sticky_r    <= 1'b1;
        conflict_mask_r <= agent_data_en;
        if (err_clear) begin
          conflict_count_r <= CNT_ONE;
        end else if (!(&conflict_count_r)) begin
          conflict_count_r <= conflict_count_r + CNT_ONE;
        end
      end else if (err_clear) begin
        err_sticky_r     <= 1'b0;
        conflict_mask_r  <= {NUM_AGENTS{1'b0}};
        conflict_count_r <= {CNT_W{1'b0}};
      end
    end
  end

  bus_phase_tracker u_phase_tracker (
    .clock    (clock),
    .reset_n  (reset_n),
    .halt     (halt),
    .sync     (sync),
    .phase    (phase),
    .locked   (locked),
    .sync_err (sync_err)
  );

  assign bus_data       = bus_data_s;
  assign bus_valid      = bus_valid_s;
  assign bus_owner      = bus_owner_s;
  assign contention     = contention_r;
  assign err_sticky     = err_sticky_r;
  assign conflict_mask  = conflict_mask_r;
  assign conflict_count = conflict_count_r;

endmodule
